// File: rtl/clk_mgr_pkg.sv
// Shared types and sizing helpers for the PLL clock/reset manager.
package clk_mgr_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILISE,
        HOLD,
        RUN
    } state_t;

    localparam int LOSS_CNT_W = 8;

    // Width of the shared lock/hold counter; it only ever counts to max-1.
    function automatic int CNT_W(input int lock_stable, input int reset_hold);
        int m;
        m = (lock_stable > reset_hold) ? lock_stable : reset_hold;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// One clock-enable channel: a down-counter that strobes at zero and reloads div-1.
module clk_en_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             ce
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             active;

    // Holding the counter at zero while idle makes the channel strobe on the
    // first active cycle, which keeps all channels phase aligned at RUN entry.
    always_comb begin
        active = run && en;
        ce     = active && (cnt_q == '0);
        cnt_d  = '0;
        if (active) begin
            if (cnt_q == '0) cnt_d = (div > DIV_W'(1)) ? div - DIV_W'(1) : '0;
            else             cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clk_rst_manager.sv
// PLL lock qualification, system reset sequencing and N_CH clock-enable dividers.
// Optional build macro CLK_RST_MANAGER_LOSS_CNT_EN adds a saturating lock-loss counter.
module clk_rst_manager
    import clk_mgr_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_STABLE = 1024,
    parameter int RESET_HOLD  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_lock,
    input  logic [N_CH*DIV_W-1:0]  div_i,
    input  logic [N_CH-1:0]        ch_en_i,
    output logic                   rst_sys_n,
    output logic [N_CH-1:0]        ce_o,
    output logic                   locked_o,
    output logic                   lock_lost_o
`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o
`endif
);

    localparam int CW = CNT_W(LOCK_STABLE, RESET_HOLD);

    logic          sync1_q, lock_s_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_sys_n_q, rst_sys_n_d;
    logic          lock_lost_q, lock_lost_d;
    logic [N_CH-1:0] ce_raw;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_lost_d = lock_lost_q;
        case (state_q)
            WAIT_LOCK: if (lock_s_q) begin state_d = STABILISE; cnt_d = '0; end
            STABILISE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK; cnt_d = '0;
                end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                    state_d = HOLD; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK; cnt_d = '0;
                end else if (cnt_q == CW'(RESET_HOLD - 1)) begin
                    state_d = RUN; cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: if (!lock_s_q) begin state_d = WAIT_LOCK; cnt_d = '0; lock_lost_d = 1'b1; end
            default: begin state_d = WAIT_LOCK; cnt_d = '0; end
        endcase
        rst_sys_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            rst_sys_n_q <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            sync1_q     <= pll_lock;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rst_sys_n_q <= rst_sys_n_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        clk_en_div #(.DIV_W(DIV_W)) u_div (
            .clk     (clk),
            .reset_n (reset_n),
            .run     (state_q == RUN),
            .en      (ch_en_i[k]),
            .div     (div_i[k*DIV_W +: DIV_W]),
            .ce      (ce_raw[k])
        );
    end

    assign rst_sys_n   = rst_sys_n_q;
    assign locked_o    = rst_sys_n_q;
    assign lock_lost_o = lock_lost_q;
    // Gate with the registered reset so strobes vanish on the very cycle RUN is left.
    assign ce_o        = ce_raw & {N_CH{rst_sys_n_q}};

`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == RUN) && !lock_s_q && (loss_cnt_q != '1))
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) loss_cnt_q <= '0;
        else          loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_clk_rst_manager.sv
// Bench for clk_rst_manager: directed scenarios plus randomized traffic against a lock-streak model.
module tb_clk_rst_manager;

    localparam int N_CH  = 4;
    localparam int DIV_W = 16;
    localparam int LS    = 8;
    localparam int RH    = 4;
    localparam int RISE  = LS + RH + 1;

    logic                  clk = 1'b0;
    logic                  reset_n, pll_lock;
    logic [N_CH*DIV_W-1:0] div_i;
    logic [N_CH-1:0]       ch_en_i, ce_o;
    logic                  rst_sys_n, locked_o, lock_lost_o;
`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
    logic [7:0]            lock_loss_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the system is running once the synchronised lock has
    // been continuously high for RISE cycles; strobes are tracked as absolute
    // due-cycles per channel.
    int cyc = 0;
    bit s1_m, ls_m, run_m, lost_m;
    int streak, loss_m;
    int nxt[N_CH];

    always #5 clk = ~clk;

    clk_rst_manager #(
        .N_CH(N_CH), .DIV_W(DIV_W), .LOCK_STABLE(LS), .RESET_HOLD(RH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_lock    (pll_lock),
        .div_i       (div_i),
        .ch_en_i     (ch_en_i),
        .rst_sys_n   (rst_sys_n),
        .ce_o        (ce_o),
        .locked_o    (locked_o),
        .lock_lost_o (lock_lost_o)
`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
        ,
        .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
    );

    function automatic int period(input int k);
        int d;
        d = int'(div_i[k*DIV_W +: DIV_W]);
        return (d < 2) ? 1 : d;
    endfunction

    function automatic logic [N_CH-1:0] ce_exp();
        logic [N_CH-1:0] e;
        for (int k = 0; k < N_CH; k++) e[k] = run_m && ch_en_i[k] && (cyc >= nxt[k]);
        return e;
    endfunction

    task automatic model_reset();
        s1_m = 0; ls_m = 0; run_m = 0; lost_m = 0; streak = 0; loss_m = 0;
        for (int k = 0; k < N_CH; k++) nxt[k] = 0;
    endtask

    // Advance one clock edge in both DUT and model; returns just after the edge.
    task automatic step();
        logic [N_CH-1:0] e;
        bit rn;
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            e = ce_exp();
            for (int k = 0; k < N_CH; k++)
                if (!(run_m && ch_en_i[k])) nxt[k] = cyc + 1;
                else if (e[k])              nxt[k] = cyc + period(k);
            streak = ls_m ? streak + 1 : 0;
            rn = (streak >= RISE);
            if (run_m && !rn) begin lost_m = 1; if (loss_m < 255) loss_m++; end
            run_m = rn; ls_m = s1_m; s1_m = pll_lock;
        end
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [DIV_W*N_CH-1:0] pack_div(input int d0, d1, d2, d3);
        return {DIV_W'(d3), DIV_W'(d2), DIV_W'(d1), DIV_W'(d0)};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; pll_lock = 1'b1; ch_en_i = '1; div_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (rst_sys_n !== 1'b0)   begin errors++; $display("FAIL reset_rst got %b exp 0", rst_sys_n); end
        checks++; if (ce_o !== '0)          begin errors++; $display("FAIL reset_ce got %b exp 0", ce_o); end
        checks++; if (locked_o !== 1'b0)    begin errors++; $display("FAIL reset_locked got %b exp 0", locked_o); end
        checks++; if (lock_lost_o !== 1'b0) begin errors++; $display("FAIL reset_lost got %b exp 0", lock_lost_o); end
`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
        checks++; if (lock_loss_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_losscnt got %0d exp 0", lock_loss_cnt_o); end
`endif
        @(posedge clk); #1;
        pll_lock = 1'b0;
        reset_n  = 1'b1;
    endtask

    // Lock steady from cycle 0: reset released at cycle LS+RH+3 = 15.
    task automatic test_lock_seq();
        pll_lock = 1'b0; ch_en_i = '0;
        apply_reset();
        for (int i = 0; i <= 20; i++) begin
            pll_lock = 1'b1;
            @(negedge clk);
            checks++; if (rst_sys_n !== (i >= 15)) begin errors++; $display("FAIL lockseq_rst cyc %0d got %b exp %b", i, rst_sys_n, i >= 15); end
            checks++; if (locked_o !== (i >= 15))  begin errors++; $display("FAIL lockseq_locked cyc %0d got %b exp %b", i, locked_o, i >= 15); end
            checks++; if (rst_sys_n !== run_m)     begin errors++; $display("FAIL lockseq_model cyc %0d got %b exp %b", i, rst_sys_n, run_m); end
            step();
        end
    endtask

    // One-cycle lock glitch during STABILISE delays release to cycle 22.
    task automatic test_glitch();
        pll_lock = 1'b0;
        apply_reset();
        for (int i = 0; i <= 26; i++) begin
            pll_lock = (i != 6);
            @(negedge clk);
            checks++; if (rst_sys_n !== (i >= 22)) begin errors++; $display("FAIL glitch_rst cyc %0d got %b exp %b", i, rst_sys_n, i >= 22); end
            checks++; if (lock_lost_o !== 1'b0)    begin errors++; $display("FAIL glitch_lost cyc %0d got %b exp 0", i, lock_lost_o); end
            step();
        end
    endtask

    // Lock dropped in RUN at cycle 20; relocked from cycle 25.
    task automatic test_lock_loss();
        pll_lock = 1'b0; ch_en_i = '1; div_i = '0;
        apply_reset();
        for (int i = 0; i <= 45; i++) begin
            bit er, el;
            pll_lock = !(i >= 20 && i < 25);
            er = (i >= 15 && i < 23) || (i >= 40);
            el = (i >= 23);
            @(negedge clk);
            checks++; if (rst_sys_n !== er)       begin errors++; $display("FAIL loss_rst cyc %0d got %b exp %b", i, rst_sys_n, er); end
            checks++; if (ce_o !== {N_CH{er}})    begin errors++; $display("FAIL loss_ce cyc %0d got %b exp %b", i, ce_o, {N_CH{er}}); end
            checks++; if (lock_lost_o !== el)     begin errors++; $display("FAIL loss_sticky cyc %0d got %b exp %b", i, lock_lost_o, el); end
            step();
        end
    endtask

    // Divisors ch0..ch3 = 4,3,1,0: all strobe on the first RUN cycle, then periods 4,3,1,1.
    task automatic test_div();
        pll_lock = 1'b1; ch_en_i = '1; div_i = pack_div(4, 3, 1, 0);
        apply_reset();
        for (int i = 0; i <= 40; i++) begin
            logic [N_CH-1:0] ex;
            int t;
            t = i - 15;
            ex = (i < 15) ? '0 : {1'b1, 1'b1, (t % 3) == 0, (t % 4) == 0};
            @(negedge clk);
            checks++; if (ce_o !== ex)       begin errors++; $display("FAIL div_ce cyc %0d got %b exp %b", i, ce_o, ex); end
            checks++; if (ce_o !== ce_exp()) begin errors++; $display("FAIL div_model cyc %0d got %b exp %b", i, ce_o, ce_exp()); end
            step();
        end
    endtask

    // Ch0 divisor 4 -> 6 two cycles into a period: strobes at t=0,4,10,16,22.
    task automatic test_div_change();
        pll_lock = 1'b1; ch_en_i = 4'b0001; div_i = pack_div(4, 0, 0, 0);
        apply_reset();
        for (int i = 0; i <= 40; i++) begin
            logic ex;
            int t;
            t = i - 15;
            if (t == 2) div_i = pack_div(6, 0, 0, 0);
            ex = (t == 0) || (t >= 4 && ((t - 4) % 6) == 0);
            @(negedge clk);
            checks++; if (ce_o[0] !== ex)    begin errors++; $display("FAIL divchg_ce cyc %0d got %b exp %b", i, ce_o[0], ex); end
            checks++; if (ce_o !== ce_exp()) begin errors++; $display("FAIL divchg_model cyc %0d got %b exp %b", i, ce_o, ce_exp()); end
            step();
        end
    endtask

    // A channel enabled in RUN strobes immediately.
    task automatic test_late_enable();
        pll_lock = 1'b1; ch_en_i = '0; div_i = pack_div(5, 5, 5, 5);
        apply_reset();
        for (int i = 0; i <= 30; i++) begin
            logic ex;
            if (i == 21) ch_en_i = 4'b0100;
            ex = (i == 21) || (i == 26);
            @(negedge clk);
            checks++; if (ce_o !== {1'b0, ex, 2'b00}) begin errors++; $display("FAIL late_ce cyc %0d got %b exp %b", i, ce_o, {1'b0, ex, 2'b00}); end
            step();
        end
    endtask

    task automatic test_random();
        int hold;
        pll_lock = 1'b0; ch_en_i = '0; div_i = '0;
        apply_reset();
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            reset_n = 1'b1;
            if (hold == 0) begin
                pll_lock = ($urandom_range(3, 0) != 0);
                hold = pll_lock ? $urandom_range(80, 5) : $urandom_range(6, 1);
            end
            hold--;
            for (int k = 0; k < N_CH; k++) begin
                if ($urandom_range(15, 0) == 0) ch_en_i[k] = ~ch_en_i[k];
                if ($urandom_range(31, 0) == 0) div_i[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(7, 0));
            end
            if ($urandom_range(999, 0) == 0) begin reset_n = 1'b0; model_reset(); end
            @(negedge clk);
            checks++; if (rst_sys_n !== run_m)    begin errors++; $display("FAIL rand_rst cyc %0d got %b exp %b", i, rst_sys_n, run_m); end
            checks++; if (locked_o !== run_m)     begin errors++; $display("FAIL rand_locked cyc %0d got %b exp %b", i, locked_o, run_m); end
            checks++; if (lock_lost_o !== lost_m) begin errors++; $display("FAIL rand_lost cyc %0d got %b exp %b", i, lock_lost_o, lost_m); end
            checks++; if (ce_o !== ce_exp())      begin errors++; $display("FAIL rand_ce cyc %0d got %b exp %b", i, ce_o, ce_exp()); end
`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
            checks++; if (lock_loss_cnt_o !== 8'(loss_m)) begin errors++; $display("FAIL rand_losscnt cyc %0d got %0d exp %0d", i, lock_loss_cnt_o, loss_m); end
`endif
            step();
        end
        reset_n = 1'b1;
    endtask

`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
    // 300 RUN->WAIT_LOCK events saturate the counter at 255; reset_n clears it.
    task automatic test_loss_cnt();
        pll_lock = 1'b0; ch_en_i = '0;
        apply_reset();
        for (int ev = 0; ev < 300; ev++) begin
            for (int c = 0; c < 24; c++) begin
                pll_lock = (c < 20);
                @(negedge clk);
                checks++; if (lock_loss_cnt_o !== 8'(loss_m)) begin errors++; $display("FAIL losscnt_model ev %0d got %0d exp %0d", ev, lock_loss_cnt_o, loss_m); end
                step();
            end
        end
        repeat (3) step();
        @(negedge clk);
        checks++; if (lock_loss_cnt_o !== 8'd255) begin errors++; $display("FAIL losscnt_sat got %0d exp 255", lock_loss_cnt_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (lock_loss_cnt_o !== 8'd0) begin errors++; $display("FAIL losscnt_clear got %0d exp 0", lock_loss_cnt_o); end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask
`endif

    // Async reset in RUN clears strobes and the system reset immediately.
    task automatic test_async_reset();
        pll_lock = 1'b1; ch_en_i = '1; div_i = '0;
        apply_reset();
        repeat (18) step();
        @(negedge clk);
        checks++; if (ce_o !== '1) begin errors++; $display("FAIL async_pre_ce got %b exp 1111", ce_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (ce_o !== '0)        begin errors++; $display("FAIL async_ce got %b exp 0", ce_o); end
        checks++; if (rst_sys_n !== 1'b0) begin errors++; $display("FAIL async_rst got %b exp 0", rst_sys_n); end
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; pll_lock = 1'b0; ch_en_i = '0; div_i = '0;
        model_reset();
        test_reset();
        test_lock_seq();
        test_glitch();
        test_lock_loss();
        test_div();
        test_div_change();
        test_late_enable();
        test_async_reset();
`ifdef CLK_RST_MANAGER_LOSS_CNT_EN
        test_loss_cnt();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
